seg_msg_scheduler: RTL and testbench
====================================

SEG_MSG_SCHEDULER -- requirements
Module: seg_msg_scheduler

Interface
REQ-001 Parameter DEPTH, default 4, FIFO entries; power of two, 2..16.
REQ-002 Parameter DWELL, default 12000000, cycles each digit is shown; range 1..2^24-1.
REQ-003 Parameter GAP, default 3000000, blank cycles between digits; range 1..2^24-1.
REQ-004 CLK  input  1  sole clock; all state updates on rising edge.
REQ-005 RST  input  1  asynchronous, active-low reset.
REQ-006 WR_EN  input  1  write strobe; one nibble is queued per cycle when high.
REQ-007 WR_DATA  input  4  hex digit to queue.
REQ-008 A,B,C,D,E,F,G  output  1 each  segment drives, active-high, registered.
REQ-009 DP  output  1  decimal point, high = more digits pending behind the one shown; registered.
REQ-010 FULL  output  1  FIFO holds DEPTH entries.
REQ-011 BUSY  output  1  FSM not in IDLE.
REQ-012 OVF  output  1  sticky: a write was dropped; cleared only by reset.

Function
REQ-013 FIFO: DEPTH x 4 bits; pointers wrap modulo DEPTH; count width clog2(DEPTH)+1.
REQ-014 Write accepted when WR_EN=1 and (count<DEPTH or pop in same cycle); accepted at the same edge as a pop leaves count unchanged.
REQ-015 Write with WR_EN=1, count=DEPTH, no pop: data discarded, pointers unchanged, OVF set at that edge.
REQ-016 FSM states: IDLE, SHOW, GAP.
REQ-017 IDLE: count>0 -> SHOW at next edge, dwell counter loaded DWELL-1; else stay.
REQ-018 SHOW: counter decrements each cycle; at 0 -> GAP, counter loaded GAP-1.
REQ-019 GAP: counter decrements; at 0 the head entry is popped at that edge; next state SHOW (counter DWELL-1) if count after pop >0 (including a write at the same edge), else IDLE.
REQ-020 Segments in SHOW = decode(head), loaded on the edge entering SHOW and held constant throughout SHOW; in IDLE and GAP all segments 0.
REQ-021 Decode, bit order {G,F,E,D,C,B,A}: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
REQ-022 DP = 1 in SHOW when count>1 (evaluated each cycle, registered, so writes during SHOW raise it one cycle later); DP = 0 in IDLE and GAP.
REQ-023 A shown digit occupies exactly DWELL cycles; GAP exactly GAP cycles; per-digit period DWELL+GAP.
REQ-024 Writes never alter the digit currently shown; head changes only by pop.
REQ-025 FULL and BUSY combinational from count and state; no other combinational input-to-output path.
REQ-026 Latency: write into empty FIFO while IDLE at edge k -> segments valid after edge k+1.

Reset
REQ-027 RST=0 asynchronously forces: state IDLE, pointers and count 0, counter 0, A..G=0, DP=0, OVF=0.
REQ-028 FIFO storage array need not be reset; its content is unobservable while count=0.
REQ-029 Reset mid-SHOW or mid-GAP discards all queued digits; after RST release operation restarts from IDLE on the first edge.
REQ-030 WR_EN during reset assertion has no effect.

Verification (DWELL=4, GAP=2, DEPTH=4)
REQ-031 Reset release, idle 10 cycles -> A..G,DP=0, BUSY=0, FULL=0, OVF=0.
REQ-032 Write 0x5 at edge k into empty IDLE -> after edge k+1 {G..A}=6D, DP=0 for 4 cycles; then 2 blank cycles; then IDLE, BUSY=0.
REQ-033 Write 0x1,0x2,0x3 on consecutive cycles -> shows 06 (DP=1), 5B (DP=1), 3F... no: 4F (DP=0), each 4 cycles separated by 2 blank cycles, no gap-to-IDLE between digits.
REQ-034 Five back-to-back writes 0x0..0x4 while IDLE -> fifth accepted only if first has been popped, otherwise dropped with FULL=1 and OVF=1 held until reset; digits 0..3 displayed in order.
REQ-035 FIFO full and write on the GAP-final edge of a pop -> write accepted, FULL stays 1, OVF unchanged.
REQ-036 RST low for 1 cycle mid-SHOW with 3 queued -> segments 0 immediately (asynchronous), count 0, no further digits displayed.

Source files
------------

// File: rtl/seg_msg_scheduler.sv
// ============================================================================
// Module   : seg_msg_scheduler
// Brief    : Queues hex digits in a small FIFO and shows them one by one on a
//            7-segment display, with a fixed dwell time and a blank gap.
// Revision : 1.0
// ============================================================================
`default_nettype none

module seg_msg_scheduler #(
    parameter int DEPTH = 4,
    parameter int DWELL = 12000000,
    parameter int GAP   = 3000000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       WR_EN,
    input  logic [3:0] WR_DATA,
    output logic       A,
    output logic       B,
    output logic       C,
    output logic       D,
    output logic       E,
    output logic       F,
    output logic       G,
    output logic       DP,
    output logic       FULL,
    output logic       BUSY,
    output logic       OVF
);

    localparam int c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CW = $clog2(DEPTH) + 1;
    localparam logic [c_CW-1:0] c_FULL_CNT = c_CW'(DEPTH);
    localparam logic [23:0]     c_DWELL_LD = 24'(DWELL - 1);
    localparam logic [23:0]     c_GAP_LD   = 24'(GAP - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SHOW = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [23:0]     r_cnt;
    logic [23:0]     w_cnt_nxt;
    logic [3:0]      r_mem [DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW-1:0] w_rd_nxt;
    logic [c_CW-1:0] r_count;
    logic [c_CW-1:0] w_count_nxt;
    logic [6:0]      r_seg;
    logic            r_dp;
    logic            r_ovf;
    logic            w_pop;
    logic            w_wr_ok;
    logic [3:0]      w_head_nxt;

    function automatic logic [6:0] f_decode(input logic [3:0] i_digit);
        logic [6:0] v;
        case (i_digit)
            4'h0: v = 7'h3F;
            4'h1: v = 7'h06;
            4'h2: v = 7'h5B;
            4'h3: v = 7'h4F;
            4'h4: v = 7'h66;
            4'h5: v = 7'h6D;
            4'h6: v = 7'h7D;
            4'h7: v = 7'h07;
            4'h8: v = 7'h7F;
            4'h9: v = 7'h6F;
            4'hA: v = 7'h77;
            4'hB: v = 7'h7C;
            4'hC: v = 7'h39;
            4'hD: v = 7'h5E;
            4'hE: v = 7'h79;
            default: v = 7'h71;
        endcase
        return v;
    endfunction

    assign w_pop       = (r_state == S_GAP) && (r_cnt == 24'd0);
    assign w_wr_ok     = WR_EN && ((r_count != c_FULL_CNT) || w_pop);
    assign w_count_nxt = r_count + c_CW'(w_wr_ok) - c_CW'(w_pop);
    assign w_rd_nxt    = r_rd_ptr + 1'b1;

    // After a pop that leaves only the same-edge write, the new head is not in
    // the array yet, so it is taken straight from the write port.
    always_comb begin
        w_head_nxt = r_mem[r_rd_ptr];
        if (w_pop) begin
            if ((r_count == c_CW'(1)) && w_wr_ok) begin
                w_head_nxt = WR_DATA;
            end else begin
                w_head_nxt = r_mem[w_rd_nxt];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (r_count != '0) begin
                    w_state_nxt = S_SHOW;
                    w_cnt_nxt   = c_DWELL_LD;
                end
            end
            S_SHOW: begin
                if (r_cnt == 24'd0) begin
                    w_state_nxt = S_GAP;
                    w_cnt_nxt   = c_GAP_LD;
                end else begin
                    w_cnt_nxt = r_cnt - 24'd1;
                end
            end
            S_GAP: begin
                if (r_cnt == 24'd0) begin
                    if (w_count_nxt != '0) begin
                        w_state_nxt = S_SHOW;
                        w_cnt_nxt   = c_DWELL_LD;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = 24'd0;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 24'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 24'd0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state  <= S_IDLE;
            r_cnt    <= 24'd0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_seg    <= 7'd0;
            r_dp     <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_count <= w_count_nxt;
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_nxt;
            end
            if (WR_EN && !w_wr_ok) begin
                r_ovf <= 1'b1;
            end
            // Segments latch only on entry to SHOW so later writes cannot disturb them.
            if (w_state_nxt == S_SHOW) begin
                if (r_state != S_SHOW) begin
                    r_seg <= f_decode(w_head_nxt);
                end
            end else begin
                r_seg <= 7'd0;
            end
            r_dp <= (w_state_nxt == S_SHOW) && (w_count_nxt > c_CW'(1));
        end
    end

    always_ff @(posedge CLK) begin
        if (w_wr_ok) begin
            r_mem[r_wr_ptr] <= WR_DATA;
        end
    end

    assign {G, F, E, D, C, B, A} = r_seg;
    assign DP   = r_dp;
    assign OVF  = r_ovf;
    assign FULL = (r_count == c_FULL_CNT);
    assign BUSY = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_seg_msg_scheduler.sv
// ============================================================================
// Module   : tb_seg_msg_scheduler
// Brief    : Directed and randomized bench for seg_msg_scheduler with a
//            queue-based timeline reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_seg_msg_scheduler;

    localparam int DEPTH = 4;
    localparam int DWELL = 4;
    localparam int GAP   = 2;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       WR_EN = 1'b0;
    logic [3:0] WR_DATA = 4'd0;
    logic       A, B, C, D, E, F, G, DP, FULL, BUSY, OVF;

    seg_msg_scheduler #(
        .DEPTH (DEPTH),
        .DWELL (DWELL),
        .GAP   (GAP)
    ) u_dut (
        .CLK     (CLK),
        .RST     (RST),
        .WR_EN   (WR_EN),
        .WR_DATA (WR_DATA),
        .A       (A),
        .B       (B),
        .C       (C),
        .D       (D),
        .E       (E),
        .F       (F),
        .G       (G),
        .DP      (DP),
        .FULL    (FULL),
        .BUSY    (BUSY),
        .OVF     (OVF)
    );

    always #5 CLK = ~CLK;

    int n_err = 0;
    int n_chk = 0;

    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Model: queue of pending digits (head = shown), plus cycles elapsed in
    // the current digit's DWELL+GAP period.
    int q[$];
    bit m_busy = 1'b0;
    int m_t    = 0;
    bit m_ovf  = 1'b0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_busy = 1'b0;
        m_t    = 0;
        m_ovf  = 1'b0;
    endtask

    task automatic model_edge(input bit we, input logic [3:0] wd);
        int  old_size;
        bit  pop;
        bit  acc;
        old_size = q.size();
        pop = m_busy && (m_t == DWELL + GAP - 1);
        acc = we && ((old_size < DEPTH) || pop);
        if (we && !acc) m_ovf = 1'b1;
        if (pop) void'(q.pop_front());
        if (acc) q.push_back(int'(wd));
        if (m_busy) begin
            if (pop) begin
                if (q.size() > 0) m_t = 0;
                else m_busy = 1'b0;
            end else begin
                m_t++;
            end
        end else if (old_size > 0) begin
            m_busy = 1'b1;
            m_t    = 0;
        end
    endtask

    task automatic check_outputs();
        logic [6:0] e_seg;
        bit         e_dp;
        e_seg = 7'd0;
        e_dp  = 1'b0;
        if (m_busy && m_t < DWELL) begin
            e_seg = seg_tab[q[0]];
            e_dp  = (q.size() > 1);
        end
        check("seg",  {25'd0, G, F, E, D, C, B, A}, {25'd0, e_seg});
        check("dp",   {31'd0, DP},   {31'd0, e_dp});
        check("full", {31'd0, FULL}, {31'd0, (q.size() == DEPTH)});
        check("busy", {31'd0, BUSY}, {31'd0, m_busy});
        check("ovf",  {31'd0, OVF},  {31'd0, m_ovf});
    endtask

    task automatic step(input bit we, input logic [3:0] wd);
        WR_EN   = we;
        WR_DATA = wd;
        @(posedge CLK);
        model_edge(we, wd);
        #1;
        WR_EN = 1'b0;
        check_outputs();
    endtask

    // Reset is applied between edges, with a write held high to show it is ignored.
    task automatic do_reset();
        RST     = 1'b0;
        WR_EN   = 1'b1;
        WR_DATA = 4'h7;
        #2;
        check("rst_seg",  {25'd0, G, F, E, D, C, B, A}, 32'd0);
        check("rst_dp",   {31'd0, DP},   32'd0);
        check("rst_busy", {31'd0, BUSY}, 32'd0);
        check("rst_full", {31'd0, FULL}, 32'd0);
        check("rst_ovf",  {31'd0, OVF},  32'd0);
        @(posedge CLK);
        #1;
        WR_EN = 1'b0;
        RST   = 1'b1;
        model_reset();
    endtask

    initial begin
        int guard;
        #1;
        do_reset();

        for (int i = 0; i < 10; i++) step(1'b0, 4'h0);

        step(1'b1, 4'h5);
        for (int i = 0; i < 12; i++) step(1'b0, 4'h0);
        check("idle_after_5", {31'd0, BUSY}, 32'd0);

        step(1'b1, 4'h1);
        step(1'b1, 4'h2);
        step(1'b1, 4'h3);
        for (int i = 0; i < 22; i++) step(1'b0, 4'h0);

        for (int i = 0; i < 5; i++) step(1'b1, 4'(i));
        check("ovf_sticky_set", {31'd0, OVF}, 32'd1);
        for (int i = 0; i < 30; i++) step(1'b0, 4'h0);
        check("ovf_held", {31'd0, OVF}, 32'd1);
        do_reset();

        for (int i = 0; i < 4; i++) step(1'b1, 4'(i + 8));
        guard = 0;
        while (!(m_busy && m_t == DWELL + GAP - 1 && q.size() == DEPTH) && guard < 20) begin
            step(1'b0, 4'h0);
            guard++;
        end
        check("pop_edge_reached", {31'd0, (guard < 20)}, 32'd1);
        step(1'b1, 4'hE);
        check("full_on_pop_write", {31'd0, FULL}, 32'd1);
        check("ovf_on_pop_write",  {31'd0, OVF},  32'd0);
        for (int i = 0; i < 30; i++) step(1'b0, 4'h0);

        step(1'b1, 4'hA);
        step(1'b1, 4'hB);
        step(1'b1, 4'hC);
        step(1'b0, 4'h0);
        do_reset();
        for (int i = 0; i < 20; i++) step(1'b0, 4'h0);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 999) == 0) begin
                do_reset();
            end else begin
                step(($urandom_range(0, 5) == 0), 4'($urandom_range(0, 15)));
            end
        end
        for (int i = 0; i < 40; i++) step(1'b0, 4'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
